// File: rtl/vcr_key_buffer_pkg.sv
// Shared types and key-code names for the VCR remote key path.
// The menu logic imports the same key constants, so they live here.
package vcr_pkg;

    localparam int KEY_W = 4;

    typedef enum logic [1:0] {
        F_EMPTY = 2'd0,
        F_HOLD  = 2'd1,
        F_ARMED = 2'd2
    } filt_state_t;

    localparam logic [KEY_W-1:0] KEY_0     = 4'h0;
    localparam logic [KEY_W-1:0] KEY_1     = 4'h1;
    localparam logic [KEY_W-1:0] KEY_2     = 4'h2;
    localparam logic [KEY_W-1:0] KEY_3     = 4'h3;
    localparam logic [KEY_W-1:0] KEY_4     = 4'h4;
    localparam logic [KEY_W-1:0] KEY_5     = 4'h5;
    localparam logic [KEY_W-1:0] KEY_6     = 4'h6;
    localparam logic [KEY_W-1:0] KEY_7     = 4'h7;
    localparam logic [KEY_W-1:0] KEY_8     = 4'h8;
    localparam logic [KEY_W-1:0] KEY_9     = 4'h9;
    localparam logic [KEY_W-1:0] KEY_ENTER = 4'hA;
    localparam logic [KEY_W-1:0] KEY_CLEAR = 4'hB;
    localparam logic [KEY_W-1:0] KEY_PLAY  = 4'hC;
    localparam logic [KEY_W-1:0] KEY_STOP  = 4'hD;
    localparam logic [KEY_W-1:0] KEY_FFWD  = 4'hE;
    localparam logic [KEY_W-1:0] KEY_REW   = 4'hF;

    function automatic logic isDigit(input logic [KEY_W-1:0] code);
        return code <= KEY_9;
    endfunction

endpackage

// File: rtl/vcr_key_buffer_key_fifo.sv
// Small circular key queue: storage, wrapping pointers and occupancy.
// A push into a full queue only lands when a pop frees a slot the same cycle.
module key_fifo #(
    parameter int DEPTH = 4,
    parameter int KEY_W = 4
) (
    input  logic                     clk_10KHz,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [KEY_W-1:0]         pushData,
    input  logic                     pop,
    output logic [KEY_W-1:0]         headData,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [KEY_W-1:0] mem [DEPTH];
    logic [PW-1:0]    wrPtr;
    logic [PW-1:0]    rdPtr;
    logic             rdEn;
    logic             wrEn;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign rdEn  = pop && !empty;
    assign wrEn  = push && (!full || rdEn);

    // Head is forced to zero when empty so a freshly reset queue reads 0.
    assign headData = empty ? '0 : mem[rdPtr];

    always_ff @(posedge clk_10KHz) begin
        if (wrEn) begin
            mem[wrPtr] <= pushData;
        end
    end

    always_ff @(posedge clk_10KHz or negedge reset_n) begin
        if (!reset_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (wrEn) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (rdEn) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({wrEn, rdEn})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vcr_key_buffer.sv
// Turns decoder output pulses into single key events, drops auto-repeats
// of a held button, and queues accepted keys for the menu logic.
module vcr_key_buffer
    import vcr_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int HOLDOFF = 1500
) (
    input  logic                     clk_10KHz,
    input  logic                     reset_n,
    input  logic                     outputting,
    input  logic [KEY_W-1:0]         vcr_out,
    input  logic                     key_ready,
    input  logic                     ovf_clear,
    output logic                     key_valid,
    output logic [KEY_W-1:0]         key_code,
    output logic [$clog2(DEPTH):0]   key_count,
    output logic                     overflow
);

    localparam int HW = $clog2(HOLDOFF + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF - 1);
    localparam logic [HW-1:0] HOLD_SAT  = HW'(HOLDOFF);

    logic             outD;
    logic             keyEvent;
    filt_state_t      filtState;
    filt_state_t      filtNext;
    logic [KEY_W-1:0] lastCode;
    logic [HW-1:0]    holdCnt;
    logic             codeMatch;
    logic             holdExpired;
    logic             acceptKey;
    logic             keyPop;
    logic             fifoFull;
    logic             fifoEmpty;
    logic             lostPush;

    // An out_d of 0 after reset makes a level already high at release count as an edge.
    always_ff @(posedge clk_10KHz or negedge reset_n) begin
        if (!reset_n) begin
            outD <= 1'b0;
        end else begin
            outD <= outputting;
        end
    end

    assign keyEvent    = outputting && !outD;
    assign codeMatch   = (vcr_out == lastCode);
    assign holdExpired = (holdCnt >= HOLD_LAST);

    always_ff @(posedge clk_10KHz or negedge reset_n) begin
        if (!reset_n) begin
            filtState <= F_EMPTY;
        end else begin
            filtState <= filtNext;
        end
    end

    always_comb begin
        filtNext = filtState;
        case (filtState)
            F_EMPTY: begin
                if (keyEvent) begin
                    filtNext = F_HOLD;
                end
            end
            F_HOLD: begin
                if (!keyEvent && holdExpired) begin
                    filtNext = F_ARMED;
                end
            end
            F_ARMED: begin
                if (keyEvent) begin
                    filtNext = F_HOLD;
                end
            end
            default: filtNext = F_EMPTY;
        endcase
    end

    // A same-code event in the last hold cycle is already outside the window.
    always_comb begin
        acceptKey = 1'b0;
        case (filtState)
            F_EMPTY: acceptKey = keyEvent;
            F_HOLD:  acceptKey = keyEvent && (!codeMatch || holdExpired);
            F_ARMED: acceptKey = keyEvent;
            default: acceptKey = 1'b0;
        endcase
    end

    // Every event, dropped or accepted, restarts the hold-off window.
    always_ff @(posedge clk_10KHz or negedge reset_n) begin
        if (!reset_n) begin
            lastCode <= '0;
            holdCnt  <= '0;
        end else begin
            if (acceptKey) begin
                lastCode <= vcr_out;
            end
            if (keyEvent) begin
                holdCnt <= '0;
            end else if (filtState != F_EMPTY && holdCnt != HOLD_SAT) begin
                holdCnt <= holdCnt + 1'b1;
            end
        end
    end

    assign keyPop   = key_valid && key_ready;
    assign lostPush = acceptKey && fifoFull && !keyPop;

    always_ff @(posedge clk_10KHz or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (lostPush) begin
            overflow <= 1'b1;
        end else if (ovf_clear) begin
            overflow <= 1'b0;
        end
    end

    key_fifo #(
        .DEPTH (DEPTH),
        .KEY_W (KEY_W)
    ) u_fifo (
        .clk_10KHz (clk_10KHz),
        .reset_n   (reset_n),
        .push      (acceptKey),
        .pushData  (vcr_out),
        .pop       (key_ready),
        .headData  (key_code),
        .full      (fifoFull),
        .empty     (fifoEmpty),
        .count     (key_count)
    );

    assign key_valid = !fifoEmpty;

endmodule

// File: tb/tb_vcr_key_buffer.sv
// Directed plus randomized bench for vcr_key_buffer, checked every cycle
// against a timestamp/queue reference model of the key filter and FIFO.
`timescale 1ns/1ps
module tb_vcr_key_buffer;
    import vcr_pkg::*;

    localparam int DEPTH   = 4;
    localparam int HOLDOFF = 1500;
    localparam int CW      = $clog2(DEPTH) + 1;

    logic             clk_10KHz = 1'b0;
    logic             reset_n;
    logic             outputting;
    logic [KEY_W-1:0] vcr_out;
    logic             key_ready;
    logic             ovf_clear;
    logic             key_valid;
    logic [KEY_W-1:0] key_code;
    logic [CW-1:0]    key_count;
    logic             overflow;

    int testCount = 0;
    int failCount = 0;

    int     mq[$];
    bit     mOvf;
    bit     mPrevOut;
    bit     mHasLast;
    int     mLastCode;
    longint mCyc;
    longint mLastEvt;

    always #5 clk_10KHz = ~clk_10KHz;

    vcr_key_buffer #(
        .DEPTH   (DEPTH),
        .HOLDOFF (HOLDOFF)
    ) dut (
        .clk_10KHz  (clk_10KHz),
        .reset_n    (reset_n),
        .outputting (outputting),
        .vcr_out    (vcr_out),
        .key_ready  (key_ready),
        .ovf_clear  (ovf_clear),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .key_count  (key_count),
        .overflow   (overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        mOvf     = 0;
        mPrevOut = 0;
        mHasLast = 0;
        mLastCode = 0;
        mLastEvt = 0;
    endtask

    // Rising-edge detection, hold-off window as elapsed cycles, queue with capacity.
    task automatic modelStep();
        bit evt;
        bit doPop;
        bit accept;
        bit lost;
        evt    = outputting && !mPrevOut;
        doPop  = (mq.size() > 0) && key_ready;
        accept = 0;
        lost   = 0;
        if (evt) begin
            accept = !(mHasLast && int'(vcr_out) == mLastCode && (mCyc - mLastEvt) <= HOLDOFF - 1);
            mLastEvt = mCyc;
            if (accept) begin
                mHasLast  = 1;
                mLastCode = int'(vcr_out);
            end
        end
        if (doPop) void'(mq.pop_front());
        if (accept) begin
            if (mq.size() < DEPTH) mq.push_back(int'(vcr_out));
            else lost = 1;
        end
        if (lost) mOvf = 1;
        else if (ovf_clear) mOvf = 0;
        mPrevOut = outputting;
        mCyc++;
    endtask

    task automatic checkOutput();
        check("key_valid", 32'(key_valid), 32'(mq.size() > 0));
        check("key_count", 32'(key_count), 32'(mq.size()));
        check("overflow", 32'(overflow), 32'(mOvf));
        if (mq.size() > 0) check("key_code", 32'(key_code), 32'(mq[0]));
    endtask

    task automatic applyStimulus(input bit o, input int code, input bit rdy, input bit clr);
        outputting = o;
        vcr_out    = KEY_W'(code);
        key_ready  = rdy;
        ovf_clear  = clr;
        modelStep();
        @(posedge clk_10KHz);
        #1;
        checkOutput();
    endtask

    task automatic pulseKey(input int code, input int hi, input int lo, input bit rdyEvent);
        applyStimulus(1, code, rdyEvent, 0);
        for (int i = 1; i < hi; i++) applyStimulus(1, code, 0, 0);
        for (int i = 0; i < lo; i++) applyStimulus(0, code, 0, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1 && mq.size() > 0; i++) applyStimulus(0, 0, 1, 0);
        check("drained", 32'(key_valid), 32'd0);
    endtask

    // Reset asserted between edges, held across one edge, released after it.
    task automatic doReset();
        reset_n = 1'b0;
        #1;
        modelReset();
        check("rst key_valid", 32'(key_valid), 32'd0);
        check("rst key_code", 32'(key_code), 32'd0);
        check("rst key_count", 32'(key_count), 32'd0);
        check("rst overflow", 32'(overflow), 32'd0);
        @(posedge clk_10KHz);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        int code;
        int hi;
        int lo;
        int r;
        outputting = 0;
        vcr_out    = '0;
        key_ready  = 0;
        ovf_clear  = 0;
        mCyc       = 0;
        doReset();
        idle(3);

        // Single 3-cycle pulse of code 5
        applyStimulus(1, 5, 0, 0);
        check("first code", 32'(key_code), 32'd5);
        check("first count", 32'(key_count), 32'd1);
        applyStimulus(1, 5, 0, 0);
        applyStimulus(1, 5, 0, 0);
        idle(5);
        check("single pulse count", 32'(key_count), 32'd1);
        drain();

        // Held button: repeats every 1100 cycles collapse to one key
        for (int i = 0; i < 6; i++) pulseKey(7, 2, 1098, 0);
        check("repeat count", 32'(key_count), 32'd1);
        idle(1500);
        pulseKey(7, 1, 5, 0);
        check("after gap count", 32'(key_count), 32'd2);
        drain();

        // Two different codes, popped in order
        pulseKey(3, 1, 199, 0);
        pulseKey(9, 1, 20, 0);
        check("order head", 32'(key_code), 32'd3);
        applyStimulus(0, 0, 1, 0);
        check("order second", 32'(key_code), 32'd9);
        applyStimulus(0, 0, 1, 0);
        check("order empty", 32'(key_valid), 32'd0);

        // Overflow with five keys into four slots
        for (int c = 1; c <= 5; c++) pulseKey(c, 1, 19, 0);
        check("ovf count", 32'(key_count), 32'd4);
        check("ovf flag", 32'(overflow), 32'd1);
        check("ovf head", 32'(key_code), 32'd1);
        applyStimulus(0, 0, 0, 1);
        check("ovf cleared", 32'(overflow), 32'd0);

        // Push and pop together while full, across pointer wrap
        for (int i = 0; i < 10; i++) begin
            pulseKey((i % 2 == 0) ? 6 : 10, 1, 2, 1);
            check("full swap count", 32'(key_count), 32'd4);
        end
        check("swap no ovf", 32'(overflow), 32'd0);
        check("wrap head", 32'(key_code), 32'd6);
        applyStimulus(0, 0, 1, 0);
        check("wrap 2nd", 32'(key_code), 32'd10);
        drain();

        // Reset mid-hold with two queued keys
        pulseKey(2, 1, 5, 0);
        pulseKey(8, 1, 5, 0);
        check("pre-reset count", 32'(key_count), 32'd2);
        doReset();
        applyStimulus(1, 8, 0, 0);
        check("post-reset accept", 32'(key_count), 32'd1);
        check("post-reset code", 32'(key_code), 32'd8);
        idle(3);

        // Randomized traffic
        for (int n = 0; n < 120; n++) begin
            code = $urandom_range(0, 3);
            hi   = $urandom_range(1, 4);
            r    = $urandom_range(0, 99);
            if (r < 50) lo = $urandom_range(1, 30);
            else if (r < 90) lo = $urandom_range(30, 1000);
            else lo = $urandom_range(1400, 1600);
            for (int i = 0; i < hi; i++)
                applyStimulus(1, code, $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0);
            if ($urandom_range(0, 29) == 0) doReset();
            for (int i = 0; i < lo; i++)
                applyStimulus(0, code, $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
